// File: rtl/divider_n_seq_if.sv
// Handshake/operand bundle for divider_n_seq: master drives Start/Ack/Xin/Yin,
// slave (the divider) returns results and one-hot state indicators.
interface divider_n_seq_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Ack;
  logic [WIDTH-1:0] Xin;
  logic [WIDTH-1:0] Yin;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Done;
  logic             DivByZero;
  logic             Qi;
  logic             Qc;
  logic             Qd;

  modport master (
    output Start, Ack, Xin, Yin,
    input  Quotient, Remainder, Done, DivByZero, Qi, Qc, Qd
  );

  modport slave (
    input  Start, Ack, Xin, Yin,
    output Quotient, Remainder, Done, DivByZero, Qi, Qc, Qd
  );
endinterface

// File: rtl/divider_n_seq.sv
// Sequential restoring divider, one quotient bit per clock, Start/Ack handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module divider_n_seq #(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  divider_n_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [1:0] QI = 2'd0;
  localparam logic [1:0] QC = 2'd1;
  localparam logic [1:0] QD = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    count;
  logic             dbz;

  logic [WIDTH:0]   r_shift;
  logic             ge;
  logic [WIDTH-1:0] r_new;
  logic [WIDTH-1:0] q_new;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    r_shift = {r, x[WIDTH-1]};
    ge      = (r_shift >= {1'b0, y});
    // Result of a successful subtract is < y, so WIDTH bits suffice.
    r_new   = ge ? (r_shift[WIDTH-1:0] - y) : r_shift[WIDTH-1:0];
    q_new   = {q[WIDTH-2:0], ge};
  end

`ifdef DIVIDER_SIGNED_EN
  logic sign_q;
  logic sign_r;

  // Most-negative input maps to 100..0, which is its correct unsigned magnitude.
  assign x_abs = bus.Xin[WIDTH-1] ? (~bus.Xin + ONE) : bus.Xin;
  assign y_abs = bus.Yin[WIDTH-1] ? (~bus.Yin + ONE) : bus.Yin;
  assign q_fin = sign_q ? (~q_new + ONE) : q_new;
  assign r_fin = sign_r ? (~r_new + ONE) : r_new;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (state == QI && bus.Start) begin
      sign_q <= bus.Xin[WIDTH-1] ^ bus.Yin[WIDTH-1];
      sign_r <= bus.Xin[WIDTH-1];
    end
  end
`else
  assign x_abs = bus.Xin;
  assign y_abs = bus.Yin;
  assign q_fin = q_new;
  assign r_fin = r_new;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= QI;
      x     <= '0;
      y     <= '0;
      q     <= '0;
      r     <= '0;
      count <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        QI: begin
          if (bus.Start) begin
            if (bus.Yin == '0) begin
              state <= QD;
              q     <= '1;
              r     <= bus.Xin;
              dbz   <= 1'b1;
            end else begin
              state <= QC;
              x     <= x_abs;
              y     <= y_abs;
              q     <= '0;
              r     <= '0;
              count <= CW'(WIDTH - 1);
              dbz   <= 1'b0;
            end
          end
        end
        QC: begin
          // Dividend shifts left so its MSB is always the next bit brought down.
          x     <= {x[WIDTH-2:0], 1'b0};
          count <= count - CW'(1);
          if (count == '0) begin
            state <= QD;
            q     <= q_fin;
            r     <= r_fin;
          end else begin
            q     <= q_new;
            r     <= r_new;
          end
        end
        QD: begin
          if (bus.Ack) state <= QI;
        end
        default: state <= QI;
      endcase
    end
  end

  assign bus.Quotient  = q;
  assign bus.Remainder = r;
  assign bus.DivByZero = dbz;
  assign bus.Qi        = (state == QI);
  assign bus.Qc        = (state == QC);
  assign bus.Qd        = (state == QD);
  assign bus.Done      = (state == QD);
endmodule

// File: tb/tb_divider_n_seq.sv
// Randomized self-checking bench for divider_n_seq (WIDTH=8 and WIDTH=16 instances)
// against an arithmetic reference model; follows DIVIDER_SIGNED_EN when defined.
module tb_divider_n_seq;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  divider_n_seq_if #(.WIDTH(8))  bus8 ();
  divider_n_seq_if #(.WIDTH(16)) bus16 ();

  divider_n_seq #(.WIDTH(8))  dut8  (.Clk(clk), .Reset_n(rst_n), .bus(bus8.slave));
  divider_n_seq #(.WIDTH(16)) dut16 (.Clk(clk), .Reset_n(rst_n), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; signed mode uses SV truncating / and %.
  task automatic ref_div(input int w, input logic [31:0] xv, input logic [31:0] yv,
                         output logic [31:0] qv, output logic [31:0] rv, output logic dz);
    logic [63:0] m;
    longint      xs;
    longint      ys;
    longint      qs;
    longint      rs;
    m  = (64'd1 << w) - 64'd1;
    dz = (yv == 0);
    if (dz) begin
      qv = 32'(m);
      rv = xv;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      xs = longint'(xv);
      ys = longint'(yv);
      if (xv[w-1]) xs = xs - (longint'(1) << w);
      if (yv[w-1]) ys = ys - (longint'(1) << w);
`else
      xs = longint'(xv);
      ys = longint'(yv);
`endif
      qs = xs / ys;
      rs = xs % ys;
      qv = 32'(64'(qs) & m);
      rv = 32'(64'(rs) & m);
    end
  endtask

  // Called one step after a rising edge with the 8-bit DUT idle in QI; leaves it in QD.
  task automatic op8(input logic [7:0] xv, input logic [7:0] yv, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          lat;
    ref_div(8, {24'b0, xv}, {24'b0, yv}, eq, er, edz);
    bus8.Xin   = xv;
    bus8.Yin   = yv;
    bus8.Start = 1'b1;
    @(posedge clk); #1;
    bus8.Start = 1'b0;
    bus8.Xin   = 8'($urandom);
    bus8.Yin   = 8'($urandom);
    lat = 0;
    while (!bus8.Done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), edz ? 32'd0 : 32'd8);
    check({tag, "_q"},   {24'b0, bus8.Quotient},  eq);
    check({tag, "_r"},   {24'b0, bus8.Remainder}, er);
    check({tag, "_dz"},  {31'b0, bus8.DivByZero}, {31'b0, edz});
    check({tag, "_st"},  {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b001);
  endtask

  task automatic ack8(input string tag);
    logic [7:0] q_hold;
    q_hold   = bus8.Quotient;
    bus8.Ack = 1'b1;
    @(posedge clk); #1;
    bus8.Ack = 1'b0;
    check({tag, "_ack_st"}, {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b100);
    check({tag, "_ack_done"}, {31'b0, bus8.Done}, 32'd0);
    check({tag, "_ack_hold"}, {24'b0, bus8.Quotient}, {24'b0, q_hold});
  endtask

  task automatic op16(input logic [15:0] xv, input logic [15:0] yv, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          lat;
    ref_div(16, {16'b0, xv}, {16'b0, yv}, eq, er, edz);
    bus16.Xin   = xv;
    bus16.Yin   = yv;
    bus16.Start = 1'b1;
    @(posedge clk); #1;
    bus16.Start = 1'b0;
    bus16.Xin   = 16'($urandom);
    bus16.Yin   = 16'($urandom);
    lat = 0;
    while (!bus16.Done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), edz ? 32'd0 : 32'd16);
    check({tag, "_q"},   {16'b0, bus16.Quotient},  eq);
    check({tag, "_r"},   {16'b0, bus16.Remainder}, er);
    check({tag, "_dz"},  {31'b0, bus16.DivByZero}, {31'b0, edz});
    bus16.Ack = 1'b1;
    @(posedge clk); #1;
    bus16.Ack = 1'b0;
    check({tag, "_ack_st"}, {29'b0, bus16.Qi, bus16.Qc, bus16.Qd}, 32'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q_hold;
    logic [7:0] r_hold;
    logic [7:0] xr;
    logic [7:0] yr;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    {bus8.Start, bus8.Ack, bus8.Xin, bus8.Yin}     = '0;
    {bus16.Start, bus16.Ack, bus16.Xin, bus16.Yin} = '0;
    #12;
    check("rst_st",   {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b100);
    check("rst_done", {31'b0, bus8.Done}, 32'd0);
    check("rst_q",    {24'b0, bus8.Quotient}, 32'd0);
    check("rst_r",    {24'b0, bus8.Remainder}, 32'd0);
    check("rst_dz",   {31'b0, bus8.DivByZero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic divide, then divide-by-zero.
    op8(8'hC8, 8'h07, "t1");
`ifndef DIVIDER_SIGNED_EN
    check("t1_lit_q", {24'b0, bus8.Quotient},  32'h1C);
    check("t1_lit_r", {24'b0, bus8.Remainder}, 32'h04);
`endif
    ack8("t1");
    op8(8'h55, 8'h00, "t2");
    check("t2_lit_q", {24'b0, bus8.Quotient},  32'hFF);
    check("t2_lit_r", {24'b0, bus8.Remainder}, 32'h55);

    // Results hold in QD while Ack is low; Start+Ack together returns to QI without a new op.
    q_hold = bus8.Quotient;
    r_hold = bus8.Remainder;
    for (int i = 0; i < 10; i++) begin
      bus8.Start = (i == 3);
      @(posedge clk); #1;
      check("t3_done", {31'b0, bus8.Done}, 32'd1);
      check("t3_q",    {24'b0, bus8.Quotient},  {24'b0, q_hold});
      check("t3_r",    {24'b0, bus8.Remainder}, {24'b0, r_hold});
    end
    bus8.Start = 1'b1;
    bus8.Ack   = 1'b1;
    bus8.Xin   = 8'h20;
    bus8.Yin   = 8'h04;
    @(posedge clk); #1;
    bus8.Start = 1'b0;
    bus8.Ack   = 1'b0;
    check("t3_both_st", {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b100);
    @(posedge clk); #1;
    check("t3_noop_st", {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b100);
    check("t3_noop_q",  {24'b0, bus8.Quotient}, {24'b0, q_hold});
    check("t3_noop_dz", {31'b0, bus8.DivByZero}, 32'd1);

    // Ack while idle is ignored.
    bus8.Ack = 1'b1;
    @(posedge clk); #1;
    bus8.Ack = 1'b0;
    check("ack_idle_st", {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b100);

    // Asynchronous reset in the middle of a computation.
    bus8.Xin   = 8'hC8;
    bus8.Yin   = 8'h07;
    bus8.Start = 1'b1;
    @(posedge clk); #1;
    bus8.Start = 1'b0;
    check("t4_qc", {31'b0, bus8.Qc}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("t4_rst_st",   {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b100);
    check("t4_rst_done", {31'b0, bus8.Done}, 32'd0);
    check("t4_rst_q",    {24'b0, bus8.Quotient}, 32'd0);
    check("t4_rst_r",    {24'b0, bus8.Remainder}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h0A, 8'h03, "t4b");
    check("t4b_lit_q", {24'b0, bus8.Quotient},  32'd3);
    check("t4b_lit_r", {24'b0, bus8.Remainder}, 32'd1);
    ack8("t4b");

    // Start held high: a new op is only accepted after the Ack round-trip.
    bus8.Xin   = 8'h64;
    bus8.Yin   = 8'h0A;
    bus8.Start = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("hold_done", {31'b0, bus8.Done}, 32'd1);
    bus8.Ack = 1'b1;
    @(posedge clk); #1;
    bus8.Ack = 1'b0;
    check("hold_ack_st", {29'b0, bus8.Qi, bus8.Qc, bus8.Qd}, 32'b100);
    @(posedge clk); #1;
    bus8.Start = 1'b0;
    check("hold_restart", {31'b0, bus8.Qc}, 32'd1);
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("hold_q2", {24'b0, bus8.Quotient}, 32'd10);
    ack8("hold");

`ifdef DIVIDER_SIGNED_EN
    op8(8'hF9, 8'h02, "s1");
    check("s1_lit_q", {24'b0, bus8.Quotient},  32'hFD);
    check("s1_lit_r", {24'b0, bus8.Remainder}, 32'hFF);
    ack8("s1");
    op8(8'h80, 8'hFF, "s2");
    check("s2_lit_q", {24'b0, bus8.Quotient},  32'h80);
    check("s2_lit_r", {24'b0, bus8.Remainder}, 32'h00);
    ack8("s2");
`endif

    // Randomized operands, biased toward zero, one and extreme values.
    for (int i = 0; i < 60; i++) begin
      xr = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       yr = 8'h00;
        1:       yr = 8'h01;
        2:       yr = 8'hFF;
        3:       yr = 8'h80;
        default: yr = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) xr = 8'h80;
      op8(xr, yr, "rnd8");
      ack8("rnd8");
    end

    // Wide instance.
    op16(16'hFFFF, 16'h0100, "t5");
    for (int i = 0; i < 8; i++) begin
      op16(16'($urandom), (i == 0) ? 16'h0000 : 16'($urandom_range(1, 65535)), "rnd16");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
